// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
// Contents: fetch FSM state enum, OKAY read response code, default reset PC.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_timer.sv
// rtl/ifu_timer.sv - 8-bit read-data wait counter for the fetch unit
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (asserted on the cycle WAIT is entered)
//   enable     : count this cycle (WAIT without read data)
//   expired    : this enabled cycle brings the count to TIMEOUT
module ifu_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count_q holds the number of empty WAIT cycles already seen, so the
    // enabled cycle at TIMEOUT-1 is the one that reaches TIMEOUT.
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: one outstanding read, hand-off to execute
// Ports:
//   clk, reset                    : clock and synchronous active-high reset
//   mem_arvalid/araddr/arready    : read-address channel (issued in REQ)
//   mem_rvalid/rdata/rresp/rready : read-data channel (accepted in WAIT)
//   ifu_valid/inst/pc, ifu_ready  : fetched instruction to execute (VALID)
//   exu_next_pc                   : next PC, sampled when the instruction is consumed
//   ifu_err                       : sticky fault (bad response, timeout, misaligned PC)
//   ifu_fetch_cnt                 : number of instructions consumed by execute
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_arvalid,
    output logic [31:0] mem_araddr,
    input  logic        mem_arready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    output logic        mem_rready,
    output logic        ifu_valid,
    output logic [31:0] ifu_inst,
    output logic [31:0] ifu_pc,
    input  logic        ifu_ready,
    input  logic [31:0] exu_next_pc,
    output logic        ifu_err,
    output logic [31:0] ifu_fetch_cnt
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    ifu_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        fetch_cnt_d  = fetch_cnt_q;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;

        case (state_q)
            REQ: begin
                if (mem_arready) begin
                    state_d     = WAIT;
                    timer_clear = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (mem_rresp == RESP_OKAY) begin
                        inst_d  = mem_rdata;
                        state_d = VALID;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    timer_enable = 1'b1;
                    if (timer_expired) begin
                        state_d = ERR;
                    end
                end
            end
            VALID: begin
                if (ifu_ready) begin
                    pc_d        = exu_next_pc;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    // A misaligned target is only detectable here, so the
                    // instruction still counts as delivered before the fault.
                    state_d     = (exu_next_pc[1:0] == 2'b00) ? REQ : ERR;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Handshake outputs decode the state register only; pc_q is the address
    // of the request in flight and of the instruction presented afterwards.
    assign mem_arvalid   = (state_q == REQ);
    assign mem_araddr    = pc_q;
    assign mem_rready    = (state_q == WAIT);
    assign ifu_valid     = (state_q == VALID);
    assign ifu_inst      = inst_q;
    assign ifu_pc        = pc_q;
    assign ifu_err       = (state_q == ERR);
    assign ifu_fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed and randomized scoreboard bench for ifu
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          TMO    = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;
    logic        ifu_valid;
    logic [31:0] ifu_inst;
    logic [31:0] ifu_pc;
    logic        ifu_ready;
    logic [31:0] exu_next_pc;
    logic        ifu_err;
    logic [31:0] ifu_fetch_cnt;

    ifu #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_arvalid   (mem_arvalid),
        .mem_araddr    (mem_araddr),
        .mem_arready   (mem_arready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_rresp     (mem_rresp),
        .mem_rready    (mem_rready),
        .ifu_valid     (ifu_valid),
        .ifu_inst      (ifu_inst),
        .ifu_pc        (ifu_pc),
        .ifu_ready     (ifu_ready),
        .exu_next_pc   (exu_next_pc),
        .ifu_err       (ifu_err),
        .ifu_fetch_cnt (ifu_fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    fetch_t      exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_cons   = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] pend_data;
    int          pend_delay;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rresp   = 2'b00;
        ifu_ready   = 1'b0;
        exu_next_pc = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    // Memory and execute-stage models for the random phase. Decisions are made
    // on the falling edge from the outputs seen there, so a handshake decided
    // here is the one the DUT takes at the next rising edge.
    task automatic drive_cycle();
        logic [31:0] d;
        logic [31:0] r;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rresp   = 2'b00;
        mem_rdata   = $urandom;
        ifu_ready   = 1'($urandom);
        exu_next_pc = $urandom;
        if (mem_arvalid) begin
            chk("rand_araddr", mem_araddr, exp_pc);
            if ($urandom_range(0, 2) != 0) begin
                mem_arready = 1'b1;
                d = $urandom;
                exp_q.push_back('{pc: exp_pc, inst: d});
                pend_data  = d;
                pend_delay = int'($urandom_range(0, 3));
            end
        end else begin
            mem_arready = 1'($urandom);
        end
        if (mem_rready) begin
            if (pend_delay == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
            end else begin
                pend_delay--;
            end
        end else begin
            mem_rvalid = 1'($urandom);
            mem_rresp  = 2'($urandom);
        end
        if (ifu_valid && ifu_ready) begin
            r = $urandom;
            exu_next_pc = {r[31:2], 2'b00};
            exp_pc      = {r[31:2], 2'b00};
        end
    endtask

    // Scoreboard monitor: every presented instruction must match the oldest
    // issued fetch, and the delivered count must match consumptions so far.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (ifu_err) begin
                    chk("rand_no_err", 32'(ifu_err), 32'd0);
                end
                if (ifu_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rand_unexpected_valid", 32'(ifu_valid), 32'd0);
                    end else begin
                        chk("rand_pc", ifu_pc, exp_q[0].pc);
                        chk("rand_inst", ifu_inst, exp_q[0].inst);
                        if (ifu_ready) begin
                            chk("rand_cnt", ifu_fetch_cnt, 32'(n_cons));
                            void'(exp_q.pop_front());
                            n_cons++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int err_at;
        reset = 1'b1;
        idle_inputs();

        // Reset state and first fetch with a zero-wait memory
        do_reset();
        chk("rst_arvalid", 32'(mem_arvalid), 32'd1);
        chk("rst_araddr", mem_araddr, RST_PC);
        chk("rst_rready", 32'(mem_rready), 32'd0);
        chk("rst_valid", 32'(ifu_valid), 32'd0);
        chk("rst_inst", ifu_inst, 32'd0);
        chk("rst_cnt", ifu_fetch_cnt, 32'd0);
        chk("rst_err", 32'(ifu_err), 32'd0);
        mem_arready = 1'b1;
        step();
        chk("t24_rready", 32'(mem_rready), 32'd1);
        chk("t24_valid_early", 32'(ifu_valid), 32'd0);
        mem_arready = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h0000_0413;
        step();
        chk("t24_valid", 32'(ifu_valid), 32'd1);
        chk("t24_inst", ifu_inst, 32'h0000_0413);
        chk("t24_pc", ifu_pc, RST_PC);
        mem_rvalid  = 1'b0;
        ifu_ready   = 1'b1;
        exu_next_pc = 32'h8000_0004;
        step();
        ifu_ready = 1'b0;
        chk("t24_cnt", ifu_fetch_cnt, 32'd1);
        chk("t24_arvalid2", 32'(mem_arvalid), 32'd1);
        chk("t24_araddr2", mem_araddr, 32'h8000_0004);

        // Address stall; stray read data in REQ must be ignored
        for (int i = 0; i < 5; i++) begin
            mem_arready = 1'b0;
            mem_rvalid  = 1'b1;
            mem_rresp   = 2'b10;
            step();
            chk("t25_arvalid", 32'(mem_arvalid), 32'd1);
            chk("t25_araddr", mem_araddr, 32'h8000_0004);
            chk("t25_rready", 32'(mem_rready), 32'd0);
        end
        chk("t25_no_err", 32'(ifu_err), 32'd0);
        mem_rvalid  = 1'b0;
        mem_rresp   = 2'b00;
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hcafe_0001;
        step();
        mem_rvalid = 1'b0;

        // Execute stalls: instruction and PC held
        for (int i = 0; i < 10; i++) begin
            ifu_ready   = 1'b0;
            exu_next_pc = $urandom;
            step();
            chk("t28_hold_valid", 32'(ifu_valid), 32'd1);
            chk("t28_hold_inst", ifu_inst, 32'hcafe_0001);
            chk("t28_hold_pc", ifu_pc, 32'h8000_0004);
        end

        // Misaligned next PC: counted, then fault with no new request
        ifu_ready   = 1'b1;
        exu_next_pc = 32'h8000_0006;
        step();
        ifu_ready = 1'b0;
        chk("t28_err", 32'(ifu_err), 32'd1);
        chk("t28_arvalid", 32'(mem_arvalid), 32'd0);
        chk("t28_valid", 32'(ifu_valid), 32'd0);
        chk("t28_cnt", ifu_fetch_cnt, 32'd2);
        for (int i = 0; i < 5; i++) begin
            mem_arready = 1'b1;
            mem_rvalid  = 1'b1;
            step();
            chk("t28_err_arvalid", 32'(mem_arvalid), 32'd0);
            chk("t28_err_sticky", 32'(ifu_err), 32'd1);
        end

        // Error response
        do_reset();
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rresp   = 2'b10;
        mem_rdata   = $urandom;
        step();
        chk("t26_err", 32'(ifu_err), 32'd1);
        chk("t26_valid", 32'(ifu_valid), 32'd0);
        mem_rvalid = 1'b0;
        mem_rresp  = 2'b00;
        for (int i = 0; i < 20; i++) begin
            mem_arready = 1'($urandom);
            mem_rvalid  = 1'($urandom);
            ifu_ready   = 1'($urandom);
            step();
            chk("t26_arvalid", 32'(mem_arvalid), 32'd0);
            chk("t26_rready", 32'(mem_rready), 32'd0);
        end

        // Read-data timeout
        do_reset();
        mem_arready = 1'b1;
        mem_rvalid  = 1'b1;
        mem_rresp   = 2'b10;
        step();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rresp   = 2'b00;
        chk("t27_rready", 32'(mem_rready), 32'd1);
        chk("t27_err_early", 32'(ifu_err), 32'd0);
        err_at = 0;
        for (int k = 2; k <= TMO + 10 && err_at == 0; k++) begin
            step();
            if (ifu_err) begin
                err_at = k;
            end
        end
        // k counts rising edges from the one entering WAIT
        chk("t27_timeout", 32'(err_at), 32'(TMO + 1));

        // Reset in the middle of a read
        do_reset();
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h1234_5678;
        step();
        mem_rvalid  = 1'b0;
        ifu_ready   = 1'b1;
        exu_next_pc = 32'h8000_0100;
        step();
        ifu_ready = 1'b0;
        chk("t29_cnt_pre", ifu_fetch_cnt, 32'd1);
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        chk("t29_in_wait", 32'(mem_rready), 32'd1);
        reset = 1'b1;
        step();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hdead_beef;
        chk("t29_arvalid", 32'(mem_arvalid), 32'd1);
        chk("t29_araddr", mem_araddr, RST_PC);
        chk("t29_cnt", ifu_fetch_cnt, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t29_late_arvalid", 32'(mem_arvalid), 32'd1);
            chk("t29_late_valid", 32'(ifu_valid), 32'd0);
        end
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        mem_rdata   = 32'h1111_1111;
        step();
        mem_rvalid = 1'b0;
        chk("t29_valid", 32'(ifu_valid), 32'd1);
        chk("t29_inst", ifu_inst, 32'h1111_1111);
        chk("t29_pc", ifu_pc, RST_PC);

        // Randomized traffic against the scoreboard
        do_reset();
        exp_pc     = RST_PC;
        pend_data  = '0;
        pend_delay = 0;
        exp_q.delete();
        n_cons = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive_cycle();
            step();
        end
        mon_en = 1'b0;
        idle_inputs();
        chk("rand_progress", 32'(n_cons >= 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h80000000, meaning the PC fetched first after reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles spent waiting for read data before a fault is raised.
REQ-003 The block SHALL have ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- mem_arvalid  out  1  read-address valid.
- mem_araddr  out  32  read address.
- mem_arready  in  1  read-address accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- mem_rresp  in  2  read response; 2'b00 = OKAY.
- mem_rready  out  1  read data accepted.
- ifu_valid  out  1  ifu_inst/ifu_pc hold a fetched instruction.
- ifu_inst  out  32  fetched instruction word.
- ifu_pc  out  32  address of ifu_inst.
- ifu_ready  in  1  execute stage consumes the instruction this cycle.
- exu_next_pc  in  32  next PC from execute; sampled only on consume.
- ifu_err  out  1  sticky fetch fault.
- ifu_fetch_cnt  out  32  count of instructions delivered.

Function
REQ-004 The FSM SHALL have four states: REQ, WAIT, VALID, ERR.
REQ-005 REQ: mem_arvalid=1 and mem_araddr=pc; on mem_arready the block SHALL go to WAIT.
REQ-006 In REQ, mem_arvalid SHALL NOT drop and mem_araddr SHALL NOT change until mem_arready.
REQ-007 WAIT: mem_rready=1. On mem_rvalid with mem_rresp==0, the block SHALL latch mem_rdata into ifu_inst and go to VALID.
REQ-008 WAIT: on mem_rvalid with mem_rresp!=0, the block SHALL go to ERR.
REQ-009 WAIT: an 8-bit wait counter SHALL clear on entry and increment each cycle without mem_rvalid; when it reaches TIMEOUT without mem_rvalid, the block SHALL go to ERR.
REQ-010 VALID: ifu_valid=1; ifu_inst and ifu_pc SHALL be held stable until ifu_ready.
REQ-011 VALID with ifu_ready: pc SHALL load exu_next_pc; ifu_fetch_cnt SHALL increment, wrapping 32'hFFFFFFFF -> 0.
REQ-012 After REQ-011, if exu_next_pc[1:0]==2'b00 the block SHALL go to REQ, otherwise to ERR.
REQ-013 ERR: ifu_err=1, mem_arvalid=0, mem_rready=0, ifu_valid=0; the block SHALL stay in ERR until reset.
REQ-014 mem_rvalid outside WAIT and mem_arready outside REQ SHALL be ignored.
REQ-015 mem_arvalid, mem_rready and ifu_valid SHALL be driven directly by state, with no combinational path from any input.
REQ-016 ifu_pc SHALL equal the address issued for the current ifu_inst.
REQ-017 Minimum throughput SHALL be one instruction per 3 cycles: REQ with arready, WAIT with rvalid, VALID with ready.

Reset
REQ-018 On reset: state=REQ, pc=RESET_PC, ifu_inst=0, ifu_fetch_cnt=0, wait counter=0, ifu_err=0.
REQ-019 Reset asserted in any state, including mid-transaction, SHALL take effect at the next posedge, abandoning any outstanding read.
REQ-020 On the first cycle after reset deasserts, mem_arvalid=1 with mem_araddr=RESET_PC.

Structure
REQ-021 Shared package ifu_pkg SHALL hold the state enum (REQ, WAIT, VALID, ERR), the RESP_OKAY=2'b00 constant and the default RESET_PC.
REQ-022 The wait counter SHALL be a sub-module ifu_timer with ports clear, enable and expired.
REQ-023 All other logic SHALL reside in ifu.

Verification
REQ-024 Reset, then zero-wait memory returning 32'h00000413, ifu_ready=1, exu_next_pc=32'h80000004 -> araddr 80000000, ifu_valid on the 3rd cycle, ifu_fetch_cnt=1, next araddr 80000004.
REQ-025 arready held low 5 cycles -> arvalid stays 1 and araddr stays stable throughout; no state change.
REQ-026 rvalid with rresp=2'b10 -> ifu_err=1 the next cycle; arvalid stays 0 for 20 further cycles.
REQ-027 rvalid never asserted -> ifu_err=1 exactly TIMEOUT cycles after entering WAIT.
REQ-028 exu_next_pc=32'h80000006 on consume -> ERR state, no new arvalid; separately, ifu_ready low 10 cycles -> ifu_inst and ifu_pc held.
REQ-029 Reset pulsed during WAIT -> next cycle arvalid=1, araddr=80000000, ifu_fetch_cnt=0; a late rvalid is ignored.
